// File: rtl/des_pkg.sv
// Shared DES constants: widths, permutation tables, S-boxes, decrypt key
// rotation schedule, FSM state type and the bit-permutation helpers.
package des_pkg;

   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Table entries are DES bit numbers: bit 1 is the MSB of the source vector.
   localparam int IP_TBL [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_TBL [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_TBL [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_TBL [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // S-box contents, row-major: entry index = {row[1:0], col[3:0]}.
   localparam int SBOX [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   // Decrypt right-rotation schedule, one bit per round (bit 0 = round 1):
   // 1 means rotate by two, 0 means rotate by one. Rounds 1..15 follow
   // 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; the round-16 rotation is never used.
   localparam logic [15:0] DEC_ROT2 = 16'h3F7E;

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
      return y;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
      return y;
   endfunction

   function automatic logic [47:0] e_expand(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
      return y;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_two);
      return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K) = P(S(E(R) xor K)); purely combinational.
module des_f
   import des_pkg::*;
(
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] f_o
);

   logic [47:0] x;
   logic [31:0] s_out;
   logic [5:0]  six;

   // Expand, mix with subkey, substitute through the eight S-boxes, permute.
   always_comb begin
      // NOTE: every variable gets a value before any conditional/loop use so no latch is inferred.
      x     = e_expand(r_i) ^ k_i;
      s_out = '0;
      six   = '0;
      for (int j = 0; j < 8; j++) begin
         six             = x[47-6*j -: 6];
         s_out[31-4*j -: 4] = 4'(SBOX[j][{six[5], six[0], six[4:1]}]);
      end
      f_o = p_perm(s_out);
   end

endmodule

// File: rtl/des_decrypt.sv
// Iterative DES decryption: one Feistel round per clock, 16 rounds per block,
// with an enable/done/ack handshake toward the controlling block.
module des_decrypt
   import des_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [BLOCK_W-1:0] message,
   input  logic [KEY_W-1:0]   DESkey,
   input  logic               enable,
   input  logic               ack,
   output logic [BLOCK_W-1:0] decrypted,
   output logic               done
);

   state_e       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [31:0]  l_q, l_d, r_q, r_d;
   logic [27:0]  c_q, c_d, d_q, d_d;
   logic [63:0]  dec_q, dec_d;
   logic         done_q, done_d;

   logic [47:0]  subkey;
   logic [31:0]  f_out;
   logic [31:0]  r_next;
   logic         rot2;

   // Subkey for the current round comes straight from the rotating C,D pair;
   // the first round sees them unrotated, which is K16.
   assign subkey = pc2_perm({c_q, d_q});
   assign r_next = l_q ^ f_out;
   assign rot2   = DEC_ROT2[cnt_q[3:0] - 4'd1];

   des_f u_f (
      .r_i (r_q),
      .k_i (subkey),
      .f_o (f_out)
   );

   // Next-state and datapath updates for IDLE / ROUND / DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      dec_d   = dec_q;
      done_d  = done_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               {l_d, r_d} = ip_perm(message);
               {c_d, d_d} = pc1_perm(DESkey);
               cnt_d      = 5'd1;
               state_d    = ST_ROUND;
            end
         end
         ST_ROUND: begin
            l_d   = r_q;
            r_d   = r_next;
            c_d   = rotr28(c_q, rot2);
            d_d   = rotr28(d_q, rot2);
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd16) begin
               // Halves are swapped before the final permutation.
               dec_d   = fp_perm({r_next, r_q});
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ack) begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; synchronous reset discards any partial block.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         dec_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         dec_q   <= dec_d;
         done_q  <= done_d;
      end
   end

   assign decrypted = dec_q;
   assign done      = done_q;

endmodule

// File: tb/tb_des_decrypt.sv
// Scoreboard bench for des_decrypt: expected plaintexts come from a textbook
// DES model (forward key schedule, subkeys applied in reverse for decryption).
module tb_des_decrypt;
   import des_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] message = '0;
   logic [63:0] DESkey = '0;
   logic        enable = 1'b0;
   logic        ack = 1'b0;
   logic [63:0] decrypted;
   logic        done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] pt;
      int          e0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic done_prev = 1'b0;

   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_decrypt dut (
      .clk       (clk),
      .reset     (reset),
      .message   (message),
      .DESkey    (DESkey),
      .enable    (enable),
      .ack       (ack),
      .decrypted (decrypted),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s, y;
      int six, row, col;
      x = '0;
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TBL[i]];
      x = x ^ k;
      s = '0;
      for (int b = 0; b < 8; b++) begin
         six = int'((x >> (42 - 6*b)) & 48'h3f);
         row = ((six >> 4) & 2) | (six & 1);
         col = (six >> 1) & 15;
         s   = (s << 4) | 32'(SBOX[b][row*16 + col]);
      end
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = s[32-P_TBL[i]];
      return y;
   endfunction

   function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [63:0] key, input bit decrypt);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] ks [16];
      logic [63:0] t, o;
      logic [31:0] l, r, tmp;
      cd = '0;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TBL[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int rnd = 0; rnd < 16; rnd++) begin
         for (int s = 0; s < SHIFTS[rnd]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         ks[rnd] = '0;
         for (int i = 0; i < 48; i++) ks[rnd][47-i] = cd[56-PC2_TBL[i]];
      end
      t = '0;
      for (int i = 0; i < 64; i++) t[63-i] = blk[64-IP_TBL[i]];
      l = t[63:32];
      r = t[31:0];
      for (int rnd = 0; rnd < 16; rnd++) begin
         tmp = r;
         r   = l ^ m_f(r, ks[decrypt ? 15 - rnd : rnd]);
         l   = tmp;
      end
      t = {r, l};
      o = '0;
      for (int i = 0; i < 64; i++) o[63-i] = t[64-FP_TBL[i]];
      return o;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && done && !done_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", decrypted, mon_e.pt);
            check("latency", 64'(cyc - mon_e.e0), 64'd16);
         end
      end
      done_prev <= done;
   end

   // ---------------- stimulus helpers (called at posedge + 1) ----------------
   task automatic start_op(input logic [63:0] m, input logic [63:0] k, input logic [63:0] exp);
      message = m;
      DESkey  = k;
      enable  = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      sb.push_back('{pt: exp, e0: cyc});
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!done) check("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
   endtask

   // Ack and enable together: ack wins, the next edge accepts the new block.
   task automatic ack_and_restart(input logic [63:0] m, input logic [63:0] k);
      message = m;
      DESkey  = k;
      ack     = 1'b1;
      enable  = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      check("b2b_done_low", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      enable = 1'b0;
      sb.push_back('{pt: m_des(m, k, 1'b1), e0: cyc});
   endtask

   initial begin
      logic [63:0] m, k, exp_pt;

      // Reset and idle behaviour.
      repeat (2) @(posedge clk);
      #1;
      check("reset_done", 64'(done), 64'd0);
      check("reset_decrypted", decrypted, 64'd0);
      reset = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         check("idle_done", 64'(done), 64'd0);
      end

      // Known-answer vector 1, with ack handling.
      start_op(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
      wait_done();
      do_ack();
      check("ack_done_low", 64'(done), 64'd0);
      check("ack_decrypted_held", decrypted, 64'h0123456789ABCDEF);

      // Known-answer vector 2.
      start_op(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787);
      wait_done();
      do_ack();

      // Model-derived vector; re-encrypting the DUT result must give the ciphertext back.
      m = 64'hE0A6FBF89265A765;
      k = 64'h133457799BBCDFF1;
      start_op(m, k, m_des(m, k, 1'b1));
      wait_done();
      check("reencrypt", m_des(decrypted, k, 1'b0), m);
      do_ack();

      // Disturb inputs during ROUND, then hold DONE without ack.
      m = {$urandom, $urandom};
      k = {$urandom, $urandom};
      exp_pt = m_des(m, k, 1'b1);
      start_op(m, k, exp_pt);
      repeat (10) begin
         message = {$urandom, $urandom};
         DESkey  = {$urandom, $urandom};
         ack     = 1'($urandom_range(1));
         enable  = 1'($urandom_range(1));
         @(posedge clk);
         #1;
      end
      ack    = 1'b0;
      enable = 1'b0;
      wait_done();
      repeat (5) begin
         @(posedge clk);
         #1;
         check("hold_done", 64'(done), 64'd1);
         check("hold_decrypted", decrypted, exp_pt);
      end
      do_ack();

      // Reset during round 8 discards the block.
      m = {$urandom, $urandom};
      k = {$urandom, $urandom};
      start_op(m, k, m_des(m, k, 1'b1));
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      check("midreset_done", 64'(done), 64'd0);
      check("midreset_decrypted", decrypted, 64'd0);
      repeat (20) begin
         @(posedge clk);
         #1;
         check("midreset_idle", 64'(done), 64'd0);
      end
      m = {$urandom, $urandom};
      k = {$urandom, $urandom};
      start_op(m, k, m_des(m, k, 1'b1));
      wait_done();

      // Random traffic, mixing idle gaps and back-to-back restarts.
      for (int n = 0; n < 16; n++) begin
         m = {$urandom, $urandom};
         k = {$urandom, $urandom};
         if ($urandom_range(1) == 1) begin
            ack_and_restart(m, k);
         end else begin
            do_ack();
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
            start_op(m, k, m_des(m, k, 1'b1));
         end
         wait_done();
      end
      do_ack();

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/des_decrypt.md
Name: des_decrypt

Overview:
- Iterative single-block DES decryption engine: 64-bit ciphertext plus 64-bit DES key in, 64-bit plaintext out.
- Executes one Feistel round per clock, 16 rounds in total.
- Uses an enable/done/ack handshake.
- Sits as a leaf compute block under a controller that presents a block, waits for done, then acknowledges.

Parameters:
- none; DES sizes are fixed.
- The block-width and key-width constants, both 64, live in the shared package.

Ports:
- clk        input   1   rising-edge clock
- reset      input   1   synchronous, active-high reset
- message    input   64  ciphertext block; bit 63 is DES bit 1
- DESkey     input   64  DES key including parity bits; parity bits 8,16,…,64 are ignored
- enable     input   1   start request; sampled only in IDLE
- ack        input   1   result acknowledge; sampled only in DONE
- decrypted  output  64  plaintext result, registered
- done       output  1   result valid, registered

Behaviour:
- Reset (synchronous, active-high, on a rising clk edge): state=IDLE, done=0, decrypted=0, round counter=0, internal L/R/C/D registers=0. Reset overrides everything, including mid-operation; the partial result is discarded.
- States: IDLE, ROUND, DONE.
- IDLE, when enable=1 on an edge (call it E0):
  - L,R <= IP(message).
  - C,D <= PC1(DESkey).
  - counter <= 1; go to ROUND.
  - message and DESkey are captured only at E0; later changes have no effect on the current block.
- IDLE, when enable=0: stay in IDLE.
- ROUND (edges E1..E16, one DES round each):
  - Round i uses subkey PC2(C,D) with the current C,D.
  - Round 1 uses C,D unrotated, which equals K16.
  - After each round, C and D are each rotated RIGHT by the decrypt schedule. For rounds 1..15 that schedule is 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Round update: L<=R, R<=L xor f(R,subkey).
  - f = P(Sbox(E(R) xor K)).
  - enable and ack are ignored while in ROUND.
- At E16 (counter=16):
  - decrypted <= FP({R16,L16}); the final swap is mandatory.
  - done <= 1; go to DONE.
  - Latency: done is high 16 edges after the accepting edge E0.
- DONE:
  - done and decrypted are held stable.
  - If ack=1 on an edge: done<=0, go to IDLE.
  - decrypted keeps its value until the next completion or reset.
- If enable is still 1 when the block returns to IDLE, a new operation starts on the next edge. Back-to-back operation is legal.
- ack while not in DONE: ignored. ack and enable both high in DONE: ack wins and the block returns to IDLE, so enable is evaluated on the following edge.
- decrypted never shows intermediate round values.

Decomposition:
- Package des_pkg holds:
  - the IP, FP, E, P, PC1 and PC2 tables;
  - the 8 S-boxes;
  - the decrypt rotate schedule;
  - a state enum for IDLE, ROUND and DONE;
  - the width constants.
- Sub-module des_f: combinational f-function, with inputs R[31:0] and K[47:0] and output [31:0].
- Key schedule, FSM and permutations stay in des_decrypt.

Test Plan:
- Reset for 2 cycles -> done=0, decrypted=0, state IDLE; enable=0 held for 10 cycles -> done stays 0.
- message=85E813540F0AB405, DESkey=133457799BBCDFF1, enable=1 -> done rises exactly 16 edges after the accepting edge; decrypted=0123456789ABCDEF; ack=1 for one cycle -> done=0 on the next edge, decrypted held.
- message=0000000000000000, DESkey=0E329232EA6D0D73 -> decrypted=8787878787878787.
- message=E0A6FBF89265A765, DESkey=133457799BBCDFF1 -> decrypted matches a software DES-decrypt reference model; encrypting that result with the same key returns E0A6FBF89265A765.
- Change message/DESkey and toggle ack during ROUND -> result unaffected, latency unchanged; done held for 5 cycles without ack -> stays 1 and decrypted is stable.
- Assert reset at round 8 -> next edge done=0, decrypted=0, IDLE; a subsequent operation produces a correct result.
